lc3_control_fsm: RTL and testbench

Multi-cycle control unit for the LC-3 core. It sits directly upstream of the datapath and drives every datapath select, load and tri-state enable from a Moore state machine. It decodes the instruction register (IR) and the NZP condition flags. It sequences fetch, decode and execute, and handshakes with memory through the MAR/MDR path.

---
 rtl/lc3_control_fsm_if.sv | 14 +
 rtl/lc3_control_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_control_fsm_if.sv
// lc3_control_fsm_if
// Memory handshake between the LC-3 control unit and the MAR/MDR memory port.
//   mem_en  : access request (control unit -> memory)
//   mem_we  : request is a write, only meaningful with mem_en
//   mem_rdy : access completes this cycle (memory -> control unit)
// master = control unit side, slave = memory side.
interface lc3_control_fsm_if;
    logic mem_en;
    logic mem_we;
    logic mem_rdy;

    modport master (output mem_en, output mem_we, input mem_rdy);
    modport slave  (input mem_en, input mem_we, output mem_rdy);
endinterface

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm
// Moore control unit for the multi-cycle LC-3 core: sequences fetch, decode
// and execute, and drives every datapath select, load and bus enable.
// Outputs depend only on the state register and IR; the single exception is
// ldPC in BR_EXEC, which also uses the N/Z/P flags.
// Ports:
//   clk, rst      : core clock, asynchronous active-high reset
//   IR            : instruction register from the datapath
//   N, Z, P       : condition flags
//   mem           : memory handshake (mem_en / mem_we out, mem_rdy in)
//   ena*          : bus tri-state enables (at most one high)
//   ld*, regWE, flagWE : register loads
//   selPC, selEAB1, selEAB2, selMAR, selMDR, aluControl : datapath selects
//   SR1, SR2, DR  : register-file addresses
//   illegal       : one-cycle pulse in DECODE for an unsupported opcode
// Build option: LC3_JSR_EN adds JSR/JSRR (opcode 0100) via JSR_EXEC.
//
// state    | meaning
// IDLE     | after reset, all outputs low
// FETCH0   | MAR <- PC, PC <- PC+1
// FETCH1   | memory read into MDR, wait for mem_rdy
// FETCH2   | IR <- MDR
// DECODE   | dispatch on opcode, flag illegal
// ALU_EXEC | ADD / AND / NOT write-back
// BR_EXEC  | conditional PC <- PC + off9
// JMP_EXEC | PC <- base register
// LEA_EXEC | DR <- PC + off9
// LD_ADDR  | MAR <- effective address (LD / LDR)
// LD_MEM   | memory read into MDR, wait for mem_rdy
// LD_WB    | DR <- MDR
// ST_ADDR  | MAR <- effective address (ST / STR)
// ST_DATA  | MDR <- SR
// ST_MEM   | memory write, wait for mem_rdy
// JSR_EXEC | R7 <- PC and PC <- target (LC3_JSR_EN only)
module lc3_control_fsm (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              IR,
    input  logic                     N,
    input  logic                     Z,
    input  logic                     P,
    lc3_control_fsm_if.master        mem,
    output logic                     enaALU,
    output logic                     enaMARM,
    output logic                     enaPC,
    output logic                     enaMDR,
    output logic                     ldPC,
    output logic                     ldIR,
    output logic                     ldMAR,
    output logic                     ldMDR,
    output logic                     regWE,
    output logic                     flagWE,
    output logic [1:0]               selPC,
    output logic                     selEAB1,
    output logic [1:0]               selEAB2,
    output logic                     selMAR,
    output logic                     selMDR,
    output logic [1:0]               aluControl,
    output logic [2:0]               SR1,
    output logic [2:0]               SR2,
    output logic [2:0]               DR,
    output logic                     illegal
);

    typedef enum logic [3:0] {
        IDLE, FETCH0, FETCH1, FETCH2, DECODE,
        ALU_EXEC, BR_EXEC, JMP_EXEC, LEA_EXEC,
        LD_ADDR, LD_MEM, LD_WB, ST_ADDR, ST_DATA, ST_MEM
`ifdef LC3_JSR_EN
        , JSR_EXEC
`endif
    } state_t;

    state_t state_q, state_d;

    logic [3:0] opcode;
    assign opcode = IR[15:12];

    // IR[5:3] carry the ADD/AND immediate flag and unused SR2 bits; the
    // datapath decodes them, the sequencer does not need them.
    logic unused_ir;
    assign unused_ir = ^IR[5:3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        mem.mem_en = 1'b0;
        mem.mem_we = 1'b0;
        enaALU     = 1'b0;
        enaMARM    = 1'b0;
        enaPC      = 1'b0;
        enaMDR     = 1'b0;
        ldPC       = 1'b0;
        ldIR       = 1'b0;
        ldMAR      = 1'b0;
        ldMDR      = 1'b0;
        regWE      = 1'b0;
        flagWE     = 1'b0;
        selPC      = 2'b00;
        selEAB1    = 1'b0;
        selEAB2    = 2'b00;
        selMAR     = 1'b0;
        selMDR     = 1'b0;
        aluControl = 2'b00;
        SR1        = 3'd0;
        SR2        = 3'd0;
        DR         = 3'd0;
        illegal    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH0;
            FETCH0: begin
                enaPC   = 1'b1;
                ldMAR   = 1'b1;
                ldPC    = 1'b1;
                state_d = FETCH1;
            end
            FETCH1: begin
                mem.mem_en = 1'b1;
                ldMDR      = 1'b1;
                selMDR     = 1'b1;
                if (mem.mem_rdy) state_d = FETCH2;
            end
            FETCH2: begin
                enaMDR  = 1'b1;
                ldIR    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    4'b0001, 4'b0101, 4'b1001: state_d = ALU_EXEC;
                    4'b0000:                   state_d = BR_EXEC;
                    4'b1100:                   state_d = JMP_EXEC;
                    4'b1110:                   state_d = LEA_EXEC;
                    4'b0010, 4'b0110:          state_d = LD_ADDR;
                    4'b0011, 4'b0111:          state_d = ST_ADDR;
`ifdef LC3_JSR_EN
                    4'b0100:                   state_d = JSR_EXEC;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH0;
                    end
                endcase
            end
            ALU_EXEC: begin
                SR1     = IR[8:6];
                SR2     = IR[2:0];
                DR      = IR[11:9];
                enaALU  = 1'b1;
                regWE   = 1'b1;
                flagWE  = 1'b1;
                if (opcode == 4'b0101)      aluControl = 2'b01;
                else if (opcode == 4'b1001) aluControl = 2'b10;
                state_d = FETCH0;
            end
            BR_EXEC: begin
                selEAB2 = 2'b10;
                selPC   = 2'b01;
                ldPC    = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
                state_d = FETCH0;
            end
            JMP_EXEC: begin
                SR1     = IR[8:6];
                selEAB1 = 1'b1;
                selPC   = 2'b01;
                ldPC    = 1'b1;
                state_d = FETCH0;
            end
            LEA_EXEC: begin
                selEAB2 = 2'b10;
                enaMARM = 1'b1;
                DR      = IR[11:9];
                regWE   = 1'b1;
                flagWE  = 1'b1;
                state_d = FETCH0;
            end
            LD_ADDR, ST_ADDR: begin
                enaMARM = 1'b1;
                ldMAR   = 1'b1;
                // IR[14] separates the base+offset forms (LDR/STR) from PC-relative.
                if (IR[14]) begin
                    selEAB1 = 1'b1;
                    SR1     = IR[8:6];
                    selEAB2 = 2'b01;
                end else begin
                    selEAB2 = 2'b10;
                end
                state_d = (state_q == LD_ADDR) ? LD_MEM : ST_DATA;
            end
            LD_MEM: begin
                mem.mem_en = 1'b1;
                ldMDR      = 1'b1;
                selMDR     = 1'b1;
                if (mem.mem_rdy) state_d = LD_WB;
            end
            LD_WB: begin
                enaMDR  = 1'b1;
                DR      = IR[11:9];
                regWE   = 1'b1;
                flagWE  = 1'b1;
                state_d = FETCH0;
            end
            ST_DATA: begin
                SR1        = IR[11:9];
                aluControl = 2'b11;
                enaALU     = 1'b1;
                ldMDR      = 1'b1;
                state_d    = ST_MEM;
            end
            ST_MEM: begin
                mem.mem_en = 1'b1;
                mem.mem_we = 1'b1;
                if (mem.mem_rdy) state_d = FETCH0;
            end
`ifdef LC3_JSR_EN
            JSR_EXEC: begin
                enaPC = 1'b1;
                DR    = 3'd7;
                regWE = 1'b1;
                selPC = 2'b01;
                ldPC  = 1'b1;
                if (IR[11]) begin
                    selEAB2 = 2'b11;
                end else begin
                    selEAB1 = 1'b1;
                    SR1     = IR[8:6];
                end
                state_d = FETCH0;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
module tb_lc3_control_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] ir;
    logic n, z, p;
    logic enaALU, enaMARM, enaPC, enaMDR, ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
    logic [1:0] selPC, selEAB2, aluControl;
    logic selEAB1, selMAR, selMDR, illegal;
    logic [2:0] SR1, SR2, DR;

    lc3_control_fsm_if mem_if ();

    lc3_control_fsm dut (
        .clk(clk), .rst(rst), .IR(ir), .N(n), .Z(z), .P(p), .mem(mem_if),
        .enaALU(enaALU), .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR),
        .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .regWE(regWE), .flagWE(flagWE), .selPC(selPC), .selEAB1(selEAB1),
        .selEAB2(selEAB2), .selMAR(selMAR), .selMDR(selMDR),
        .aluControl(aluControl), .SR1(SR1), .SR2(SR2), .DR(DR), .illegal(illegal)
    );

    typedef struct packed {
        logic       mem_en, mem_we, ena_alu, ena_marm, ena_pc, ena_mdr;
        logic       ld_pc, ld_ir, ld_mar, ld_mdr, reg_we, flag_we;
        logic [1:0] sel_pc;
        logic       sel_eab1;
        logic [1:0] sel_eab2;
        logic       sel_mar, sel_mdr;
        logic [1:0] alu;
        logic [2:0] sr1, sr2, dr;
        logic       illegal;
    } outs_t;

    outs_t obs;
    assign obs = {mem_if.mem_en, mem_if.mem_we, enaALU, enaMARM, enaPC, enaMDR,
                  ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, selPC, selEAB1,
                  selEAB2, selMAR, selMDR, aluControl, SR1, SR2, DR, illegal};

    // Micro-steps of an instruction as seen from outside the control unit.
    typedef enum int {P_IDLE, P_F0, P_F1, P_F2, P_DEC, P_ALU, P_BR, P_JMP, P_LEA,
                      P_ADDR, P_MRD, P_WB, P_DATA, P_MWR, P_JSR} ph_t;

    int checks = 0;
    int errors = 0;
    int fixed_nzp = -1;
    ph_t seq[$];

    function automatic bit jsr_enabled();
`ifdef LC3_JSR_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b1110,
            4'b0010, 4'b0110, 4'b0011, 4'b0111: return 1'b1;
            4'b0100: return jsr_enabled();
            default: return 1'b0;
        endcase
    endfunction

    function automatic outs_t expect_out(input ph_t ph, input logic [15:0] i,
                                         input logic fn, input logic fz, input logic fp);
        outs_t e;
        logic [3:0] op;
        e  = '0;
        op = i[15:12];
        case (ph)
            P_F0:  begin e.ena_pc = 1; e.ld_mar = 1; e.ld_pc = 1; end
            P_F1, P_MRD: begin e.mem_en = 1; e.ld_mdr = 1; e.sel_mdr = 1; end
            P_F2:  begin e.ena_mdr = 1; e.ld_ir = 1; end
            P_DEC: e.illegal = !is_legal(op);
            P_ALU: begin
                e.sr1 = i[8:6]; e.sr2 = i[2:0]; e.dr = i[11:9];
                e.ena_alu = 1; e.reg_we = 1; e.flag_we = 1;
                e.alu = (op == 4'b0101) ? 2'd1 : (op == 4'b1001) ? 2'd2 : 2'd0;
            end
            P_BR: begin
                e.sel_eab2 = 2'b10; e.sel_pc = 2'b01;
                e.ld_pc = (i[11] & fn) | (i[10] & fz) | (i[9] & fp);
            end
            P_JMP: begin e.sr1 = i[8:6]; e.sel_eab1 = 1; e.sel_pc = 2'b01; e.ld_pc = 1; end
            P_LEA: begin
                e.sel_eab2 = 2'b10; e.ena_marm = 1; e.dr = i[11:9];
                e.reg_we = 1; e.flag_we = 1;
            end
            P_ADDR: begin
                e.ena_marm = 1; e.ld_mar = 1;
                if (op == 4'b0110 || op == 4'b0111) begin
                    e.sel_eab1 = 1; e.sr1 = i[8:6]; e.sel_eab2 = 2'b01;
                end else e.sel_eab2 = 2'b10;
            end
            P_WB:   begin e.ena_mdr = 1; e.dr = i[11:9]; e.reg_we = 1; e.flag_we = 1; end
            P_DATA: begin e.sr1 = i[11:9]; e.alu = 2'b11; e.ena_alu = 1; e.ld_mdr = 1; end
            P_MWR:  begin e.mem_en = 1; e.mem_we = 1; end
            P_JSR: begin
                e.ena_pc = 1; e.dr = 3'd7; e.reg_we = 1; e.sel_pc = 2'b01; e.ld_pc = 1;
                if (i[11]) e.sel_eab2 = 2'b11;
                else begin e.sel_eab1 = 1; e.sr1 = i[8:6]; end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic build(input logic [15:0] instr);
        logic [3:0] op;
        op = instr[15:12];
        seq = '{P_F0, P_F1, P_F2, P_DEC};
        case (op)
            4'b0001, 4'b0101, 4'b1001: seq.push_back(P_ALU);
            4'b0000: seq.push_back(P_BR);
            4'b1100: seq.push_back(P_JMP);
            4'b1110: seq.push_back(P_LEA);
            4'b0010, 4'b0110: begin seq.push_back(P_ADDR); seq.push_back(P_MRD); seq.push_back(P_WB); end
            4'b0011, 4'b0111: begin seq.push_back(P_ADDR); seq.push_back(P_DATA); seq.push_back(P_MWR); end
            4'b0100: if (jsr_enabled()) seq.push_back(P_JSR);
            default: ;
        endcase
    endtask

    task automatic check(input outs_t e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        checks++;
        assert ($countones({enaALU, enaMARM, enaPC, enaMDR}) <= 1) else begin
            errors++;
            $error("FAIL %s_onehot observed=%b expected=at_most_one", tag,
                   {enaALU, enaMARM, enaPC, enaMDR});
        end
    endtask

    // Drives one instruction through the control unit; stall < 0 means random.
    task automatic run_instr(input logic [15:0] instr, input int fstall,
                             input int mstall, input string tag);
        int stall;
        ph_t ph;
        logic [2:0] f;
        build(instr);
        for (int k = 0; k < seq.size(); k++) begin
            ph = seq[k];
            stall = 0;
            if (ph == P_F1) stall = fstall;
            else if (ph == P_MRD || ph == P_MWR) stall = mstall;
            if (stall < 0) stall = $urandom_range(0, 2);
            for (int c = 0; c <= stall; c++) begin
                @(posedge clk); #1;
                f = (fixed_nzp >= 0) ? 3'(fixed_nzp) : 3'($urandom_range(0, 7));
                {n, z, p} = f;
                if (ph == P_DEC) ir = instr;
                if (ph == P_F1 || ph == P_MRD || ph == P_MWR) mem_if.mem_rdy = (c == stall);
                else mem_if.mem_rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                check(expect_out(ph, ir, n, z, p), $sformatf("%s_s%0d_c%0d", tag, k, c));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ir = 16'h0000;
        {n, z, p} = 3'b000;
        mem_if.mem_rdy = 1'b1;
        @(negedge clk);
        check('0, "reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check('0, "idle_after_reset");

        run_instr(16'h1283, 0, 0, "add");
        fixed_nzp = 3'b010;
        run_instr(16'h0405, 0, 0, "brz_taken");
        fixed_nzp = 3'b101;
        run_instr(16'h0405, 0, 0, "brz_not_taken");
        fixed_nzp = -1;
        run_instr(16'h0E07, 1, 0, "brnzp");
        run_instr(16'h2A02, 0, 3, "ld_wait3");
        run_instr(16'h7642, 0, 2, "str");
        run_instr(16'h3C10, 0, 0, "st");
        run_instr(16'h6A81, 2, 1, "ldr");
        run_instr(16'hF025, 0, 0, "trap");
        run_instr(16'h4803, 0, 0, "jsr");
        run_instr(16'h4080, 0, 0, "jsrr");
        run_instr(16'h5A6F, 0, 0, "and");
        run_instr(16'h9A3F, 0, 0, "not");
        run_instr(16'hC1C0, 0, 0, "jmp");
        run_instr(16'hE5FE, 0, 0, "lea");
        run_instr(16'hD000, 0, 0, "reserved");

        // Reset during a stalled instruction fetch.
        @(posedge clk); #1; mem_if.mem_rdy = 1'b0;
        @(negedge clk); check(expect_out(P_F0, ir, n, z, p), "rst_f0");
        @(posedge clk); #1; mem_if.mem_rdy = 1'b0;
        @(negedge clk); check(expect_out(P_F1, ir, n, z, p), "rst_f1a");
        @(posedge clk); #1; mem_if.mem_rdy = 1'b0;
        @(negedge clk); check(expect_out(P_F1, ir, n, z, p), "rst_f1b");
        #1 rst = 1'b1;
        #1;
        checks++;
        assert (mem_if.mem_en === 1'b0) else begin
            errors++;
            $error("FAIL rst_mem_en observed=%b expected=0", mem_if.mem_en);
        end
        check('0, "rst_async_outputs");
        @(posedge clk); #1;
        rst = 1'b0;
        mem_if.mem_rdy = 1'b1;
        @(negedge clk);
        check('0, "rst_idle");
        run_instr(16'h1283, 0, 0, "add_after_rst");

        for (int r = 0; r < 40; r++)
            run_instr(16'($urandom), -1, -1, $sformatf("rand%0d", r));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
